// File: rtl/cell_cfg_loader.sv
// Framed byte-stream writer for C2/S2 mux cells: validates each
// header/index/payload/checksum record and holds one config word until committed.
module cell_cfg_loader #(
    parameter int N      = 4,
    parameter int NCELLS = 8,
    localparam int CFG_W  = 4 * N + 4,
    localparam int ADDR_W = (NCELLS > 1) ? $clog2(NCELLS) : 1
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic [CFG_W-1:0]  cfg_data,
    output logic              cfg_valid,
    input  logic              cfg_ready,
    output logic              frame_err,
    output logic [7:0]        frame_cnt
);

    localparam int CFG_BYTES = (CFG_W + 7) / 8;
    localparam int CNT_W     = (CFG_BYTES > 1) ? $clog2(CFG_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(CFG_BYTES - 1);
    localparam logic [7:0] HEADER = 8'hA5;

    typedef enum logic [2:0] {
        S_HUNT,
        S_INDEX,
        S_PAYLOAD,
        S_CHECK,
        S_HOLD
    } state_t;

    state_t state, state_nxt;

    logic             rdy_en;
    logic [7:0]       idx;
    logic [7:0]       csum;
    logic [CNT_W-1:0] cnt;
    logic [CFG_W-1:0] payload;
    logic             xfer;
    logic             commit;
    logic             idx_ok;
    logic             rec_good;

    // rdy_en keeps in_ready low until the first edge after reset release
    assign in_ready = rdy_en && (state != S_HOLD);
    assign xfer     = in_valid && in_ready;
    assign commit   = cfg_valid && cfg_ready;
    assign idx_ok   = ({24'd0, idx} < 32'(NCELLS));
    assign rec_good = idx_ok && (csum == in_data);

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) state <= S_HUNT;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_HUNT:    if (xfer && in_data == HEADER) state_nxt = S_INDEX;
            S_INDEX:   if (xfer) state_nxt = S_PAYLOAD;
            S_PAYLOAD: if (xfer && cnt == LAST_BYTE) state_nxt = S_CHECK;
            S_CHECK:   if (xfer) state_nxt = rec_good ? S_HOLD : S_HUNT;
            S_HOLD:    if (commit) state_nxt = S_HUNT;
            default:   state_nxt = S_HUNT;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            rdy_en    <= 1'b0;
            idx       <= '0;
            csum      <= '0;
            cnt       <= '0;
            payload   <= '0;
            cfg_addr  <= '0;
            cfg_data  <= '0;
            cfg_valid <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            rdy_en    <= 1'b1;
            frame_err <= 1'b0;
            case (state)
                S_INDEX: if (xfer) begin
                    idx  <= in_data;
                    csum <= in_data;
                    cnt  <= '0;
                end
                S_PAYLOAD: if (xfer) begin
                    // only bits below CFG_W are stored; the rest still feed the checksum
                    for (int unsigned i = 0; i < CFG_W; i++) begin
                        if (cnt == CNT_W'(i / 8)) payload[i] <= in_data[3'(i % 8)];
                    end
                    csum <= csum ^ in_data;
                    cnt  <= cnt + 1'b1;
                end
                S_CHECK: if (xfer) begin
                    if (rec_good) begin
                        cfg_valid <= 1'b1;
                        cfg_addr  <= idx[ADDR_W-1:0];
                        cfg_data  <= payload;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                S_HOLD: if (commit) begin
                    cfg_valid <= 1'b0;
                    frame_cnt <= frame_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
